// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_pkg
// Brief    : Shared MDU operation codes, FSM state type and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

  // Multiply/divide unit operation codes carried on md_op.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Controller states: idle (accepting work) or running a multi-cycle op.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  // True for the two divide ops (they use the longer cycle count).
  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Brief    : Multi-cycle multiply/divide controller owning the HI/LO registers.
//            Issues mult/multu/div/divu from E-stage, holds busy for a fixed
//            cycle count, then commits the 64-bit result into HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  // Counter wide enough for the longer of the two latencies.
  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles < 2) ? 1 : $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  // State and datapath registers with their next-state values.
  mdu_state_e         r_state_q, w_state_d;
  logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
  logic [3:0]         r_op_q,    w_op_d;
  logic [31:0]        r_a_q,     w_a_d;
  logic [31:0]        r_b_q,     w_b_d;
  logic [31:0]        r_hi_q,    w_hi_d;
  logic [31:0]        r_lo_q,    w_lo_d;

  // Arithmetic on the latched operands.
  logic               w_issue;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_divisor;
  logic [31:0]        w_quo_s;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_valid;

  // A new op is taken only from IDLE, so completion and re-issue never share a cycle.
  assign w_issue = (r_state_q == ST_IDLE) && start && !flush && is_md_arith(md_op);

  // Both products are formed at 64 bits so the upper half is exact.
  assign w_prod_s = $signed({{32{r_a_q[31]}}, r_a_q}) * $signed({{32{r_b_q[31]}}, r_b_q});
  assign w_prod_u = {32'b0, r_a_q} * {32'b0, r_b_q};

  // Divisor forced to 1 when zero so the dividers never see x; that result is discarded.
  assign w_divisor = (r_b_q == 32'd0) ? 32'd1 : r_b_q;
  assign w_quo_s   = $signed(r_a_q) / $signed(w_divisor);
  assign w_rem_s   = $signed(r_a_q) % $signed(w_divisor);
  assign w_quo_u   = r_a_q / w_divisor;
  assign w_rem_u   = r_a_q % w_divisor;

  // Select the HI/LO pair for the in-flight op; divide by zero leaves HI/LO alone.
  always_comb begin
    w_res_hi    = 32'd0;
    w_res_lo    = 32'd0;
    w_res_valid = 1'b0;
    case (r_op_q)
      MD_MULT: begin
        w_res_hi    = w_prod_s[63:32];
        w_res_lo    = w_prod_s[31:0];
        w_res_valid = 1'b1;
      end
      MD_MULTU: begin
        w_res_hi    = w_prod_u[63:32];
        w_res_lo    = w_prod_u[31:0];
        w_res_valid = 1'b1;
      end
      MD_DIV: begin
        w_res_hi    = w_rem_s;
        w_res_lo    = w_quo_s;
        w_res_valid = (r_b_q != 32'd0);
      end
      MD_DIVU: begin
        w_res_hi    = w_rem_u;
        w_res_lo    = w_quo_u;
        w_res_valid = (r_b_q != 32'd0);
      end
      default: begin
        w_res_valid = 1'b0;
      end
    endcase
  end

  // Next-state logic: issue/MT* from IDLE, count down and commit in RUN.
  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_op_d    = r_op_q;
    w_a_d     = r_a_q;
    w_b_d     = r_b_q;
    w_hi_d    = r_hi_q;
    w_lo_d    = r_lo_q;
    case (r_state_q)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_d = ST_RUN;
          w_cnt_d   = is_md_div(md_op) ? c_div_load : c_mult_load;
          w_op_d    = md_op;
          w_a_d     = A;
          w_b_d     = B;
        end else if (!flush) begin
          if (md_op == MD_MTHI) begin
            w_hi_d = A;
          end else if (md_op == MD_MTLO) begin
            w_lo_d = A;
          end
        end
      end
      ST_RUN: begin
        // Inputs are ignored here: flush, start and MT* cannot disturb the op.
        if (r_cnt_q <= c_cnt_one) begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
          if (w_res_valid) begin
            w_hi_d = w_res_hi;
            w_lo_d = w_res_lo;
          end
        end else begin
          w_cnt_d = r_cnt_q - c_cnt_one;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  // State register; reset drops any in-flight result and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= ST_IDLE;
      r_cnt_q   <= '0;
      r_op_q    <= 4'd0;
      r_a_q     <= 32'd0;
      r_b_q     <= 32'd0;
      r_hi_q    <= 32'd0;
      r_lo_q    <= 32'd0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_op_q    <= w_op_d;
      r_a_q     <= w_a_d;
      r_b_q     <= w_b_d;
      r_hi_q    <= w_hi_d;
      r_lo_q    <= w_lo_d;
    end
  end

  assign busy = (r_state_q == ST_RUN);
  assign HI   = r_hi_q;
  assign LO   = r_lo_q;

  // Move-from read port; combinational so MFHI/MFLO see HI/LO without delay.
  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI) begin
      md_out = r_hi_q;
    end else if (md_op == MD_MFLO) begin
      md_out = r_lo_q;
    end
  end

endmodule : mdu_ctrl
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: E-stage mult/multu/div/divu issue pulse.
REQ-006 SHALL have port md_op, input, 4: operation code from the shared package.
REQ-007 SHALL have port A, input, 32: rs operand, already forwarded.
REQ-008 SHALL have port B, input, 32: rt operand, already forwarded.
REQ-009 SHALL have port flush, input, 1: exception/interrupt request; cancels this cycle's issue.
REQ-010 SHALL have port busy, output, 1: operation in progress; feeds the hazard unit's MDU stall term.
REQ-011 SHALL have port HI, output, 32: architectural HI register.
REQ-012 SHALL have port LO, output, 32: architectural LO register.
REQ-013 SHALL have port md_out, output, 32: HI when md_op=MFHI, LO when md_op=MFLO, else 0; combinational.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; reset state is IDLE.
REQ-015 IDLE -> RUN SHALL occur on start=1, flush=0, and md_op in {MULT, MULTU, DIV, DIVU}.
- Operands latched on the same edge.
- Counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL be 1 exactly while in RUN: from the cycle after start for N cycles, N = the loaded count.
REQ-017 In RUN the counter SHALL decrement by 1 per cycle; at count 1:
- HI/LO written with the result on that edge.
- FSM returns to IDLE.
REQ-018 MULT SHALL form a signed 64-bit product; MULTU an unsigned 64-bit product; HI = bits 63:32, LO = bits 31:0.
REQ-019 DIV/DIVU SHALL set LO = quotient and HI = remainder.
- Signed DIV truncates toward zero; the remainder takes the sign of the dividend.
REQ-020 DIV/DIVU with B=0 SHALL run the full DIV_CYCLES with HI/LO left unchanged.
REQ-021 MTHI/MTLO SHALL write A to HI/LO in one cycle, without start, only when in IDLE and flush=0.
REQ-022 start or MTHI/MTLO arriving while in RUN SHALL be ignored; the in-flight operation completes unaffected.
REQ-023 flush SHALL NOT abort an operation already in RUN; it only suppresses issue in the same cycle.
REQ-024 start with md_op outside {MULT, MULTU, DIV, DIVU} SHALL be ignored.
REQ-025 Completion and a new start in the same cycle SHALL NOT overlap: a new start is accepted only in the cycle after busy falls.

Reset
REQ-026 reset SHALL, on the next edge, force FSM=IDLE, counter=0, busy=0, HI=0, LO=0, and clear the operand latches.
REQ-027 reset asserted mid-operation SHALL discard the in-flight result; HI/LO read 0 after reset.

Structure
REQ-028 The MD_* op codes SHALL live in the shared macro/package file alongside existing control macros:
- NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
REQ-029 The cycle-count parameters SHALL be overridable at instantiation; no separate sub-module, arithmetic inline.

Verification
REQ-030 MULT: A=3, B=FFFFFFFE, start 1 cycle -> busy=1 for 5 cycles, then HI=FFFFFFFF, LO=FFFFFFFA.
REQ-031 MULTU: same operands -> HI=00000002, LO=FFFFFFFA after 5 busy cycles.
REQ-032 DIV: A=FFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=FFFFFFFD, HI=FFFFFFFF; DIVU with B=0 -> HI/LO unchanged.
REQ-033 start=1 with flush=1 -> busy stays 0, HI/LO unchanged; MTHI with flush=1 -> HI unchanged.
REQ-034 MTLO A=12345678 issued during RUN -> ignored; LO equals the mult result on completion.
REQ-035 reset pulsed at RUN cycle 3 of DIV -> next cycle busy=0, HI=LO=0; no later write occurs.
